// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder
// Receive-side VGA timing recovery. Detects H/V sync falling edges, rebuilds
// the pixel (h) and line (v) indices, measures line and frame periods, runs a
// lock FSM against the expected mode and emits coordinate-tagged pixels once
// the incoming timing has been confirmed over consecutive good frames.
// Every output is registered, one cycle after the input sample it describes.
module vga_timing_decoder #(
   parameter int X_START  = 144,
   parameter int Y_START  = 35,
   parameter int H_ACT    = 640,
   parameter int V_ACT    = 480,
   parameter int H_PERIOD = 800,
   parameter int V_PERIOD = 525
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iVGA_H_SYNC,
   input  logic        iVGA_V_SYNC,
   input  logic [9:0]  iVGA_R,
   input  logic [9:0]  iVGA_G,
   input  logic [9:0]  iVGA_B,
   output logic [9:0]  oRed,
   output logic [9:0]  oGreen,
   output logic [9:0]  oBlue,
   output logic [9:0]  oCoord_X,
   output logic [9:0]  oCoord_Y,
   output logic        oData_Valid,
   output logic        oFrame_Start,
   output logic [10:0] oH_Total,
   output logic [10:0] oV_Total,
   output logic        oLocked
);

   // Lock FSM encoding
   localparam logic [1:0] S_SEARCH  = 2'd0;
   localparam logic [1:0] S_MEASURE = 2'd1;
   localparam logic [1:0] S_VERIFY  = 2'd2;
   localparam logic [1:0] S_LOCKED  = 2'd3;

   // Counter ceiling: h reaching this value means the sync has been lost
   localparam logic [10:0] C_SAT      = 11'd2047;
   localparam logic [10:0] C_X_START  = 11'(X_START);
   localparam logic [10:0] C_X_END    = 11'(X_START + H_ACT);
   localparam logic [10:0] C_Y_START  = 11'(Y_START);
   localparam logic [10:0] C_Y_END    = 11'(Y_START + V_ACT);
   localparam logic [10:0] C_H_PERIOD = 11'(H_PERIOD);
   localparam logic [10:0] C_V_PERIOD = 11'(V_PERIOD);

   // Registered state
   logic        r_hs_d;
   logic        r_vs_d;
   logic [10:0] r_h;
   logic [10:0] r_v;
   logic        r_v_pending;
   logic        r_h_seen;
   logic        r_frame_seen;
   logic        r_frame_bad;
   logic [1:0]  r_state;

   // Per-cycle decode of the current input sample
   logic        w_h_edge;
   logic        w_v_edge;
   logic        w_frame_start;
   logic        w_line_bad;
   logic        w_frame_good;
   logic        w_sync_loss;
   logic        w_active;
   logic        w_valid;
   logic [10:0] w_h_inc;
   logic [10:0] w_v_inc;
   logic [10:0] w_h;
   logic [10:0] w_v;
   logic [1:0]  w_state_nxt;

   assign w_h_edge      = r_hs_d & ~iVGA_H_SYNC;
   assign w_v_edge      = r_vs_d & ~iVGA_V_SYNC;
   // A V edge on the H-edge cycle counts immediately; otherwise it waits in v_pending
   assign w_frame_start = w_h_edge & (r_v_pending | w_v_edge);

   // Saturating successors; w_h_inc is also the measured period of the line just ended
   assign w_h_inc = (r_h == C_SAT) ? C_SAT : r_h + 11'd1;
   assign w_v_inc = (r_v == C_SAT) ? C_SAT : r_v + 11'd1;

   assign w_h = w_h_edge ? 11'd0 : w_h_inc;
   assign w_v = w_frame_start ? 11'd0 : (w_h_edge ? w_v_inc : r_v);

   assign w_line_bad   = w_h_edge & r_h_seen & (w_h_inc != C_H_PERIOD);
   // The line closed by the frame-start edge still belongs to the frame being judged
   assign w_frame_good = r_frame_seen & (w_v_inc == C_V_PERIOD) & ~r_frame_bad & ~w_line_bad;
   assign w_sync_loss  = (w_h == C_SAT);

   assign w_active = (w_h >= C_X_START) && (w_h < C_X_END) &&
                     (w_v >= C_Y_START) && (w_v < C_Y_END);
   assign w_valid  = w_active && (r_state == S_LOCKED);

   // Lock FSM next-state: sync loss wins, then frame-start verdicts, then mid-frame bad lines
   always_comb begin
      // NOTE: default assignment first so no path leaves w_state_nxt unassigned (no latch).
      w_state_nxt = r_state;
      if (w_sync_loss) begin
         w_state_nxt = S_SEARCH;
      end else if (w_frame_start) begin
         case (r_state)
            S_SEARCH:  w_state_nxt = S_MEASURE;
            S_MEASURE: w_state_nxt = w_frame_good ? S_VERIFY : S_MEASURE;
            S_VERIFY:  w_state_nxt = w_frame_good ? S_LOCKED : S_MEASURE;
            default:   w_state_nxt = w_frame_good ? S_LOCKED : S_MEASURE;
         endcase
      end else if ((r_state == S_LOCKED) && w_line_bad) begin
         w_state_nxt = S_MEASURE;
      end
   end

   // Sync edge history and the h/v position counters
   always_ff @(posedge iCLK) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      if (iRST) begin
         r_hs_d <= 1'b0;
         r_vs_d <= 1'b0;
         r_h    <= 11'd0;
         r_v    <= 11'd0;
      end else begin
         r_hs_d <= iVGA_H_SYNC;
         r_vs_d <= iVGA_V_SYNC;
         r_h    <= w_h;
         r_v    <= w_v;
      end
   end

   // Frame bookkeeping flags and the lock FSM state register
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_v_pending  <= 1'b0;
         r_h_seen     <= 1'b0;
         r_frame_seen <= 1'b0;
         r_frame_bad  <= 1'b0;
         r_state      <= S_SEARCH;
      end else begin
         if (w_h_edge) begin
            r_h_seen <= 1'b1;
         end
         if (w_frame_start) begin
            r_frame_seen <= 1'b1;
         end
         if (w_frame_start) begin
            r_v_pending <= 1'b0;
         end else if (w_v_edge) begin
            r_v_pending <= 1'b1;
         end
         if (w_frame_start) begin
            r_frame_bad <= 1'b0;
         end else if (w_line_bad) begin
            r_frame_bad <= 1'b1;
         end
         r_state <= w_state_nxt;
      end
   end

   // Registered outputs: measurements, coordinates, gated colour and status
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         oRed         <= 10'd0;
         oGreen       <= 10'd0;
         oBlue        <= 10'd0;
         oCoord_X     <= 10'd0;
         oCoord_Y     <= 10'd0;
         oData_Valid  <= 1'b0;
         oFrame_Start <= 1'b0;
         oH_Total     <= 11'd0;
         oV_Total     <= 11'd0;
         oLocked      <= 1'b0;
      end else begin
         if (w_h_edge && r_h_seen) begin
            oH_Total <= w_h_inc;
         end
         if (w_frame_start && r_frame_seen) begin
            oV_Total <= w_v_inc;
         end
         if (w_active) begin
            oCoord_X <= 10'(w_h - C_X_START);
            oCoord_Y <= 10'(w_v - C_Y_START);
         end
         oRed         <= w_valid ? iVGA_R : 10'd0;
         oGreen       <= w_valid ? iVGA_G : 10'd0;
         oBlue        <= w_valid ? iVGA_B : 10'd0;
         oData_Valid  <= w_valid;
         oFrame_Start <= w_frame_start;
         oLocked      <= (w_state_nxt == S_LOCKED);
      end
   end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// tb_vga_timing_decoder
// Drives a scaled-down VGA-style mode (64-clock lines, 20-line frames) so that
// full lock/relock sequences fit in a short run. A line generator pushes the
// expected per-cycle outputs into a queue as it drives each sample; they are
// popped and compared one cycle later when the DUT presents its result.
module tb_vga_timing_decoder;

   localparam int XS     = 12;
   localparam int HA     = 40;
   localparam int YS     = 3;
   localparam int VA     = 12;
   localparam int HP     = 64;
   localparam int VP     = 20;
   localparam int HS_W   = 8;   // hsync low width
   localparam int VS_OFF = 30;  // mid-line vsync fall position
   localparam int RST_H  = 30;  // pixel at which a mid-frame reset is applied

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iVGA_H_SYNC;
   logic        iVGA_V_SYNC;
   logic [9:0]  iVGA_R;
   logic [9:0]  iVGA_G;
   logic [9:0]  iVGA_B;
   logic [9:0]  oRed;
   logic [9:0]  oGreen;
   logic [9:0]  oBlue;
   logic [9:0]  oCoord_X;
   logic [9:0]  oCoord_Y;
   logic        oData_Valid;
   logic        oFrame_Start;
   logic [10:0] oH_Total;
   logic [10:0] oV_Total;
   logic        oLocked;

   always #5 iCLK = ~iCLK;

   vga_timing_decoder #(
      .X_START (XS),
      .Y_START (YS),
      .H_ACT   (HA),
      .V_ACT   (VA),
      .H_PERIOD(HP),
      .V_PERIOD(VP)
   ) u_dut (
      .iCLK        (iCLK),
      .iRST        (iRST),
      .iVGA_H_SYNC (iVGA_H_SYNC),
      .iVGA_V_SYNC (iVGA_V_SYNC),
      .iVGA_R      (iVGA_R),
      .iVGA_G      (iVGA_G),
      .iVGA_B      (iVGA_B),
      .oRed        (oRed),
      .oGreen      (oGreen),
      .oBlue       (oBlue),
      .oCoord_X    (oCoord_X),
      .oCoord_Y    (oCoord_Y),
      .oData_Valid (oData_Valid),
      .oFrame_Start(oFrame_Start),
      .oH_Total    (oH_Total),
      .oV_Total    (oV_Total),
      .oLocked     (oLocked)
   );

   typedef struct {
      logic       valid;
      logic       fs;
      logic       locked;
      logic [9:0] x;
      logic [9:0] y;
      logic [9:0] r;
      logic [9:0] g;
      logic [9:0] b;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   // Observations collected by run_frame for the scenario tasks
   int          valid_cnt;
   logic        seen_valid;
   logic [9:0]  first_x, first_y, first_r;
   logic [9:0]  last_x, last_y, last_r;
   logic [10:0] frame_vtot;
   logic [10:0] stretch_htot;

   // Drive one input sample, queue its expectation, then retire the oldest expectation
   task automatic drive_cycle(input logic rst, input logic hs, input logic vs,
                              input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                              input exp_t e);
      exp_t x;
      iRST        = rst;
      iVGA_H_SYNC = hs;
      iVGA_V_SYNC = vs;
      iVGA_R      = r;
      iVGA_G      = g;
      iVGA_B      = b;
      exp_q.push_back(e);
      @(posedge iCLK);
      #1;
      x = exp_q.pop_front();
      n_cmp += 3;
      if (oData_Valid !== x.valid) begin
         n_err++;
         $display("FAIL valid t=%0t actual=%b required=%b", $time, oData_Valid, x.valid);
      end
      if (oFrame_Start !== x.fs) begin
         n_err++;
         $display("FAIL frame_start t=%0t actual=%b required=%b", $time, oFrame_Start, x.fs);
      end
      if (oLocked !== x.locked) begin
         n_err++;
         $display("FAIL locked t=%0t actual=%b required=%b", $time, oLocked, x.locked);
      end
      if (x.valid) begin
         n_cmp += 2;
         if (oCoord_X !== x.x) begin
            n_err++;
            $display("FAIL coord_x t=%0t actual=%0d required=%0d", $time, oCoord_X, x.x);
         end
         if (oCoord_Y !== x.y) begin
            n_err++;
            $display("FAIL coord_y t=%0t actual=%0d required=%0d", $time, oCoord_Y, x.y);
         end
      end
      n_cmp += 3;
      if (oRed !== (x.valid ? x.r : 10'd0)) begin
         n_err++;
         $display("FAIL red t=%0t actual=%0d required=%0d", $time, oRed, x.valid ? x.r : 10'd0);
      end
      if (oGreen !== (x.valid ? x.g : 10'd0)) begin
         n_err++;
         $display("FAIL green t=%0t actual=%0d required=%0d", $time, oGreen, x.valid ? x.g : 10'd0);
      end
      if (oBlue !== (x.valid ? x.b : 10'd0)) begin
         n_err++;
         $display("FAIL blue t=%0t actual=%0d required=%0d", $time, oBlue, x.valid ? x.b : 10'd0);
      end
      if (oData_Valid === 1'b1) begin
         valid_cnt++;
         if (!seen_valid) begin
            seen_valid = 1'b1;
            first_x = oCoord_X;
            first_y = oCoord_Y;
            first_r = oRed;
         end
         last_x = oCoord_X;
         last_y = oCoord_Y;
         last_r = oRed;
      end
   endtask

   // Syncs idle high for n cycles; no edges, so nothing changes except the lock expectation
   task automatic idle(input int n, input logic lock);
      exp_t e;
      e = '{valid: 1'b0, fs: 1'b0, locked: lock, x: 10'd0, y: 10'd0, r: 10'd0, g: 10'd0, b: 10'd0};
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 10'd0, e);
   endtask

   // One generated frame. lock = expected lock from its frame-start cycle on.
   // stretch >= 0 lengthens that line by one clock; vs_mid moves the next vsync
   // fall to VS_OFF inside the last line; rst_line >= 0 pulses reset mid-frame.
   task automatic run_frame(input logic lock, input int stretch, input logic vs_mid,
                            input int rst_line);
      logic cur_lock;
      cur_lock   = lock;
      valid_cnt  = 0;
      seen_valid = 1'b0;
      for (int v = 0; v < VP; v++) begin
         int len;
         len = (v == stretch) ? HP + 1 : HP;
         for (int h = 0; h < len; h++) begin
            logic hs, vs, rst, act;
            exp_t e;
            hs  = (h < HS_W) ? 1'b0 : 1'b1;
            if (vs_mid) vs = ((v == 0) || (v == VP - 1 && h >= VS_OFF)) ? 1'b0 : 1'b1;
            else        vs = (v < 2) ? 1'b0 : 1'b1;
            rst = (v == rst_line) && (h == RST_H);
            act = (h >= XS) && (h < XS + HA) && (v >= YS) && (v < YS + VA);
            e.valid = act && cur_lock && !rst;
            if (stretch >= 0 && v == stretch + 1 && h == 0) cur_lock = 1'b0;
            if (rst) cur_lock = 1'b0;
            e.locked = cur_lock;
            e.fs     = (h == 0) && (v == 0);
            e.x      = 10'(h - XS);
            e.y      = 10'(v - YS);
            e.r      = 10'(h);
            e.g      = 10'(v);
            e.b      = 10'(h * 3 + v * 7);
            drive_cycle(rst, hs, vs, e.r, e.g, e.b, e);
            if (v == 0 && h == 0) frame_vtot = oV_Total;
            if (stretch >= 0 && v == stretch + 1 && h == 0) stretch_htot = oH_Total;
            if (rst) begin
               n_cmp += 4;
               if (oH_Total !== 11'd0 || oV_Total !== 11'd0) begin
                  n_err++;
                  $display("FAIL rst_totals actual=%0d/%0d required=0/0", oH_Total, oV_Total);
               end
               if (oCoord_X !== 10'd0 || oCoord_Y !== 10'd0) begin
                  n_err++;
                  $display("FAIL rst_coords actual=%0d/%0d required=0/0", oCoord_X, oCoord_Y);
               end
               if (oFrame_Start !== 1'b0 || oData_Valid !== 1'b0) begin
                  n_err++;
                  $display("FAIL rst_flags actual=%b%b required=00", oFrame_Start, oData_Valid);
               end
               if ({oRed, oGreen, oBlue} !== 30'd0 || oLocked !== 1'b0) begin
                  n_err++;
                  $display("FAIL rst_colour actual=%0h/%b required=0/0", {oRed, oGreen, oBlue}, oLocked);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      exp_t e;
      e = '{valid: 1'b0, fs: 1'b0, locked: 1'b0, x: 10'd0, y: 10'd0, r: 10'd0, g: 10'd0, b: 10'd0};
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b1, 10'h3ff, 10'h3ff, 10'h3ff, e);
      n_cmp += 3;
      if (oH_Total !== 11'd0 || oV_Total !== 11'd0) begin
         n_err++;
         $display("FAIL reset_totals actual=%0d/%0d required=0/0", oH_Total, oV_Total);
      end
      if (oCoord_X !== 10'd0 || oCoord_Y !== 10'd0) begin
         n_err++;
         $display("FAIL reset_coords actual=%0d/%0d required=0/0", oCoord_X, oCoord_Y);
      end
      if (oFrame_Start !== 1'b0 || oLocked !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flags actual=%b%b required=00", oFrame_Start, oLocked);
      end
      idle(4, 1'b0);
   endtask

   task automatic test_lock_acquire();
      run_frame(1'b0, -1, 1'b0, -1);
      run_frame(1'b0, -1, 1'b0, -1);
      run_frame(1'b1, -1, 1'b0, -1);
      n_cmp += 3;
      if (oH_Total !== 11'(HP)) begin
         n_err++;
         $display("FAIL acquire_h_total actual=%0d required=%0d", oH_Total, HP);
      end
      if (oV_Total !== 11'(VP)) begin
         n_err++;
         $display("FAIL acquire_v_total actual=%0d required=%0d", oV_Total, VP);
      end
      if (valid_cnt != HA * VA) begin
         n_err++;
         $display("FAIL acquire_valid_count actual=%0d required=%0d", valid_cnt, HA * VA);
      end
   endtask

   task automatic test_coords();
      run_frame(1'b1, -1, 1'b0, -1);
      n_cmp += 3;
      if (!seen_valid || first_x !== 10'd0 || first_y !== 10'd0 || first_r !== 10'(XS)) begin
         n_err++;
         $display("FAIL first_pixel actual=%0d,%0d,r%0d required=0,0,r%0d", first_x, first_y, first_r, XS);
      end
      if (last_x !== 10'(HA - 1) || last_y !== 10'(VA - 1) || last_r !== 10'(XS + HA - 1)) begin
         n_err++;
         $display("FAIL last_pixel actual=%0d,%0d,r%0d required=%0d,%0d,r%0d",
                  last_x, last_y, last_r, HA - 1, VA - 1, XS + HA - 1);
      end
      if (valid_cnt != HA * VA) begin
         n_err++;
         $display("FAIL coords_valid_count actual=%0d required=%0d", valid_cnt, HA * VA);
      end
   endtask

   task automatic test_stretch();
      run_frame(1'b1, 5, 1'b0, -1);
      n_cmp++;
      if (stretch_htot !== 11'(HP + 1)) begin
         n_err++;
         $display("FAIL stretch_h_total actual=%0d required=%0d", stretch_htot, HP + 1);
      end
      run_frame(1'b0, -1, 1'b0, -1);
      run_frame(1'b0, -1, 1'b0, -1);
      run_frame(1'b1, -1, 1'b0, -1);
      n_cmp++;
      if (oH_Total !== 11'(HP)) begin
         n_err++;
         $display("FAIL stretch_recovered_h_total actual=%0d required=%0d", oH_Total, HP);
      end
   endtask

   task automatic test_vsync_phase();
      // Frame start on a coincident V/H edge, then one on a V edge that arrived mid-line
      run_frame(1'b1, -1, 1'b1, -1);
      n_cmp++;
      if (frame_vtot !== 11'(VP)) begin
         n_err++;
         $display("FAIL coincident_v_total actual=%0d required=%0d", frame_vtot, VP);
      end
      run_frame(1'b1, -1, 1'b0, -1);
      n_cmp++;
      if (frame_vtot !== 11'(VP)) begin
         n_err++;
         $display("FAIL midline_v_total actual=%0d required=%0d", frame_vtot, VP);
      end
   endtask

   task automatic test_sync_loss();
      exp_t e;
      e = '{valid: 1'b0, fs: 1'b0, locked: 1'b1, x: 10'd0, y: 10'd0, r: 10'd0, g: 10'd0, b: 10'd0};
      // The last line ran h = 0..HP-1, so hold cycle i sees h = HP + i
      for (int i = 0; i < 2100; i++) begin
         e.locked = (HP + i < 2047);
         drive_cycle(1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 10'd0, e);
      end
      n_cmp += 3;
      if (oLocked !== 1'b0) begin
         n_err++;
         $display("FAIL sync_loss_locked actual=%b required=0", oLocked);
      end
      if (oH_Total !== 11'(HP)) begin
         n_err++;
         $display("FAIL sync_loss_h_total actual=%0d required=%0d", oH_Total, HP);
      end
      if (oV_Total !== 11'(VP)) begin
         n_err++;
         $display("FAIL sync_loss_v_total actual=%0d required=%0d", oV_Total, VP);
      end
      // Back from SEARCH needs three frame starts
      run_frame(1'b0, -1, 1'b0, -1);
      run_frame(1'b0, -1, 1'b0, -1);
      run_frame(1'b1, -1, 1'b0, -1);
   endtask

   task automatic test_mid_reset();
      run_frame(1'b1, -1, 1'b0, 10);
      run_frame(1'b0, -1, 1'b0, -1);
      run_frame(1'b0, -1, 1'b0, -1);
      run_frame(1'b1, -1, 1'b0, -1);
      n_cmp++;
      if (valid_cnt != HA * VA) begin
         n_err++;
         $display("FAIL relock_valid_count actual=%0d required=%0d", valid_cnt, HA * VA);
      end
   endtask

   initial begin
      iRST        = 1'b1;
      iVGA_H_SYNC = 1'b1;
      iVGA_V_SYNC = 1'b1;
      iVGA_R      = 10'd0;
      iVGA_G      = 10'd0;
      iVGA_B      = 10'd0;
      valid_cnt   = 0;
      seen_valid  = 1'b0;
      test_reset();
      test_lock_acquire();
      test_coords();
      test_stretch();
      test_vsync_phase();
      test_sync_loss();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
